// File: rtl/three_way_pkg.sv
// Shared 3-Way cipher types and the theta diffusion transform.
// Key-schedule and inverse-cipher blocks reuse theta() from here.
package three_way_pkg;

  typedef logic [31:0] word_t;
  typedef logic [95:0] block_t;

  // One output word of theta; x is the word in the same lane, y and z are the next two lanes.
  function automatic word_t thetaLane(input word_t x, input word_t y, input word_t z);
    return x ^ (x >> 16) ^ (y << 16) ^ (y >> 16) ^ (z << 16) ^ (y >> 24) ^ (z << 8)
             ^ (z >> 8) ^ (x << 24) ^ (z >> 16) ^ (x << 16) ^ (z >> 24) ^ (x << 8);
  endfunction

  function automatic block_t theta(input block_t a);
    word_t a0, a1, a2;
    a0 = a[31:0];
    a1 = a[63:32];
    a2 = a[95:64];
    return {thetaLane(a2, a0, a1), thetaLane(a1, a2, a0), thetaLane(a0, a1, a2)};
  endfunction

endpackage

// File: rtl/linear_theta.sv
// Theta diffusion layer of the 3-Way round datapath.
// Optionally registers the result for one cycle of latency with valid tracking.
module linear_theta
  import three_way_pkg::*;
#(
  parameter bit REGISTERED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [95:0] iword,
  output logic        out_valid,
  output logic [95:0] oword
);

  block_t thetaResult;
  assign thetaResult = theta(iword);

  if (REGISTERED) begin : gReg
    block_t oword_q, oword_d;
    logic   out_valid_q, out_valid_d;

    assign oword_d     = thetaResult;
    assign out_valid_d = in_valid;

    // The data path updates every cycle; consumers qualify it with out_valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        oword_q     <= '0;
        out_valid_q <= 1'b0;
      end else begin
        oword_q     <= oword_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign oword     = oword_q;
    assign out_valid = out_valid_q;
  end else begin : gComb
    logic unusedClkRst;
    assign unusedClkRst = clk ^ rst;

    assign oword     = thetaResult;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_linear_theta.sv
// Self-checking bench for linear_theta: registered and combinational variants
// compared against a bit-level reference model of the theta shift table.
module tb_linear_theta;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [95:0] iword;
  logic        outValidReg, outValidComb;
  logic [95:0] owordReg, owordComb;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  linear_theta #(.REGISTERED(1'b1)) dutReg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .iword(iword),
    .out_valid(outValidReg), .oword(owordReg)
  );

  linear_theta #(.REGISTERED(1'b0)) dutComb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .iword(iword),
    .out_valid(outValidComb), .oword(owordComb)
  );

  // Each term: source lane offset relative to the output lane, and a signed
  // shift (positive = left, negative = right).
  int termLane[13]  = '{0, 0,   1,  1,   2,  1,   2, 2,  0,  2,   0,  2,   0};
  int termShift[13] = '{0, -16, 16, -16, 16, -24, 8, -8, 24, -16, 16, -24, 8};

  function automatic logic [95:0] refTheta(input logic [95:0] a);
    logic [95:0] b;
    b = '0;
    for (int lane = 0; lane < 3; lane++)
      for (int bitIdx = 0; bitIdx < 32; bitIdx++)
        for (int t = 0; t < 13; t++) begin
          int src;
          int srcLane;
          src     = bitIdx - termShift[t];
          srcLane = (lane + termLane[t]) % 3;
          if (src >= 0 && src < 32)
            b[lane*32 + bitIdx] = b[lane*32 + bitIdx] ^ a[srcLane*32 + src];
        end
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check the combinational
  // instance, then check the registered instance just after the rising edge.
  task automatic applyStimulus(input string tag, input logic rstV, input logic validV,
                               input logic [95:0] wordV, input logic [95:0] expWord);
    @(negedge clk);
    rst      = rstV;
    in_valid = validV;
    iword    = wordV;
    #1;
    checkOutput({tag, "/comb"}, owordComb, expWord);
    checkOutput({tag, "/combValid"}, {95'b0, outValidComb}, {95'b0, validV});
    @(posedge clk);
    #1;
    checkOutput({tag, "/reg"}, owordReg, rstV ? 96'h0 : expWord);
    checkOutput({tag, "/regValid"}, {95'b0, outValidReg}, {95'b0, validV & ~rstV});
  endtask

  function automatic logic [95:0] randBlock();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [95:0] x, y, w, held;
    rst = 1'b1;
    in_valid = 1'b0;
    iword = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetWord", owordReg, 96'h0);
    checkOutput("resetValid", {95'b0, outValidReg}, 96'h0);

    // Reset dominates a simultaneous valid input.
    applyStimulus("resetPriority", 1'b1, 1'b1, 96'h1, refTheta(96'h1));

    // Directed vectors with hand-derived expectations.
    applyStimulus("zero", 1'b0, 1'b1, 96'h0, 96'h0);
    applyStimulus("singleBitA0", 1'b0, 1'b1, {32'h0, 32'h0, 32'h1},
                  {32'h00010000, 32'h00010100, 32'h01010101});
    applyStimulus("fullWordA0", 1'b0, 1'b1, {32'h0, 32'h0, 32'hFFFFFFFF},
                  {32'hFFFFFF00, 32'h00FFFFFF, 32'h00FFFF00});
    applyStimulus("singleBitA1", 1'b0, 1'b1, {32'h0, 32'h1, 32'h0},
                  {32'h00010100, 32'h01010101, 32'h00010000});
    applyStimulus("singleBitA2", 1'b0, 1'b0, {32'h1, 32'h0, 32'h0},
                  {32'h01010101, 32'h00010000, 32'h00010100});

    // Linearity over random pairs, streamed back-to-back.
    for (int i = 0; i < 100; i++) begin
      x = randBlock();
      y = randBlock();
      applyStimulus("linX", 1'b0, 1'($urandom_range(0, 1)), x, refTheta(x));
      applyStimulus("linXY", 1'b0, 1'b1, x ^ y, refTheta(x) ^ refTheta(y));
    end

    // Reset mid-stream, then resume.
    w = randBlock();
    applyStimulus("preReset", 1'b0, 1'b1, w, refTheta(w));
    w = randBlock();
    applyStimulus("midReset", 1'b1, 1'b1, w, refTheta(w));
    applyStimulus("midReset2", 1'b1, 1'b0, w, refTheta(w));
    held = randBlock();
    applyStimulus("resume", 1'b0, 1'b1, held, refTheta(held));
    for (int i = 0; i < 20; i++) begin
      w = randBlock();
      applyStimulus("stream", 1'b0, 1'b1, w, refTheta(w));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
